// File: rtl/branch_pc_unit_if.sv
// branch_pc_if: control/status bundle between the decode/execute side
// (master) and the PC unit (slave).
//   master drives: stall, branch_en, flag_ctl, ALU flags, offset, call, ret,
//                  jr_en, jr_target
//   slave drives:  pc, pc_plus4, taken, ras_empty, ras_full, ras_err
//                  (+ align_trap when PC_ALIGN_TRAP_EN is defined)
interface branch_pc_if #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 30
);
  logic              stall;
  logic              branch_en;
  logic [3:0]        flag_ctl;
  logic              zero_flag;
  logic              sign_flag;
  logic              carry_flag;
  logic              overflow_flag;
  logic [OFF_W-1:0]  offset;
  logic              call;
  logic              ret;
  logic              jr_en;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              taken;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;
`ifdef PC_ALIGN_TRAP_EN
  logic              align_trap;
`endif

  modport master (
    output stall, branch_en, flag_ctl, zero_flag, sign_flag, carry_flag,
           overflow_flag, offset, call, ret, jr_en, jr_target,
    input  pc, pc_plus4, taken, ras_empty, ras_full, ras_err
`ifdef PC_ALIGN_TRAP_EN
  , input  align_trap
`endif
  );

  modport slave (
    input  stall, branch_en, flag_ctl, zero_flag, sign_flag, carry_flag,
           overflow_flag, offset, call, ret, jr_en, jr_target,
    output pc, pc_plus4, taken, ras_empty, ras_full, ras_err
`ifdef PC_ALIGN_TRAP_EN
  , output align_trap
`endif
  );
endinterface

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: registered PC with next-PC selection and a circular
// return-address stack.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : branch_pc_if.slave -- controls in, pc/pc_plus4/taken and
//                RAS status out
// Next-PC priority: ret > jr_en > taken branch > pc+4. stall freezes pc,
// RAS and ras_err; combinational outputs keep tracking inputs.
// Optional macro PC_ALIGN_TRAP_EN: adds sticky align_trap and forces
// bits [1:0] of misaligned jr/ret targets to zero.
// Assumes OFF_W < ADDR_W and RAS_DEPTH a power of two.
module branch_pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                OFF_W     = 30,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  branch_pc_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0]                 pc_q, pc_d;
  logic [RAS_DEPTH-1:0][ADDR_W-1:0]  ras_q, ras_d;
  logic [PTR_W-1:0]                  sp_q, sp_d;   // next write slot
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              err_q, err_d;
`ifdef PC_ALIGN_TRAP_EN
  logic                              trap_q, trap_d;
`endif

  logic [ADDR_W-1:0] pc_plus4, off_ext, br_tgt, nxt, ras_top;
  logic              flag_sel, cond, taken;

  always_comb begin
    pc_plus4 = pc_q + ADDR_W'(4);
    off_ext  = {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
    br_tgt   = pc_plus4 + {off_ext[ADDR_W-3:0], 2'b00};

    case (bus.flag_ctl[2:1])
      2'b00:   flag_sel = bus.sign_flag;
      2'b01:   flag_sel = bus.overflow_flag;
      2'b10:   flag_sel = bus.zero_flag;
      default: flag_sel = bus.carry_flag;
    endcase
    cond  = (flag_sel ^ bus.flag_ctl[0]) | (bus.flag_ctl[3] & bus.flag_ctl[2]);
    taken = cond & bus.branch_en;

    // Top of stack sits one below the write pointer (wraps circularly).
    ras_top = ras_q[sp_q - PTR_W'(1)];

    pc_d  = pc_q;
    ras_d = ras_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    nxt   = pc_plus4;
`ifdef PC_ALIGN_TRAP_EN
    trap_d = trap_q;
`endif

    if (!bus.stall) begin
      if (bus.ret) begin
        if (cnt_q != '0) begin
          nxt   = ras_top;
          sp_d  = sp_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.jr_en) begin
        nxt = bus.jr_target;
      end else if (taken) begin
        nxt = br_tgt;
      end

      // Push slot is free by construction: when full it holds the oldest
      // entry, which is exactly what gets overwritten.
      if (taken && bus.call && !bus.ret) begin
        ras_d[sp_q] = pc_plus4;
        sp_d        = sp_q + PTR_W'(1);
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      end

`ifdef PC_ALIGN_TRAP_EN
      if (((bus.ret && cnt_q != '0) || (!bus.ret && bus.jr_en)) &&
          nxt[1:0] != 2'b00) begin
        trap_d   = 1'b1;
        nxt[1:0] = 2'b00;
      end
`endif
      pc_d = nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      ras_q  <= '0;
      sp_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef PC_ALIGN_TRAP_EN
      trap_q <= 1'b0;
`endif
    end else begin
      pc_q   <= pc_d;
      ras_q  <= ras_d;
      sp_q   <= sp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
`ifdef PC_ALIGN_TRAP_EN
      trap_q <= trap_d;
`endif
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.taken     = taken;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == CNT_FULL);
  assign bus.ras_err   = err_q;
`ifdef PC_ALIGN_TRAP_EN
  assign bus.align_trap = trap_q;
`endif
endmodule
